// File: rtl/multdiv_sched.sv
// multdiv_sched: round-robin scheduler sharing one multdiv unit between two
// requesters. Latches one request, issues a single start pulse, waits for
// resultRDY under a watchdog and returns a tagged response with backpressure.
module multdiv_sched #(
  parameter int unsigned TIMEOUT = 80,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_b1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic [1:0]       req_ready,
  output logic [31:0]      md_operandA,
  output logic [31:0]      md_operandB,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  input  logic [31:0]      md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_result,
  output logic             resp_exception,
  output logic             resp_timeout,
  output logic             busy
);

  localparam int unsigned    CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic               ptr;
  logic               grant_any;
  logic               grant_id;
  logic               accept;
  logic               op_q;
  logic               id_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CW-1:0]      cnt;
  logic [31:0]        res_q;
  logic               exc_q;
  logic               to_q;
  logic               rdy_ok;
  logic               tmo;

  // Arbitration: a lone requester wins; on contention the pointer decides.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    unique case (req_valid)
      2'b01:   begin grant_any = 1'b1; grant_id = 1'b0; end
      2'b10:   begin grant_any = 1'b1; grant_id = 1'b1; end
      2'b11:   begin grant_any = 1'b1; grant_id = ptr;  end
      default: begin grant_any = 1'b0; grant_id = 1'b0; end
    endcase
  end

  assign accept = (state == IDLE) && grant_any;
  // Ready from a stale RDY in the first BUSY cycle is not trusted.
  assign rdy_ok = (cnt != '0) && md_resultRDY;
  assign tmo    = (cnt == CNT_LAST);

  // Grant is offered only in IDLE and is forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if ((state == IDLE) && grant_any && !reset)
      req_ready[grant_id] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = BUSY;
      BUSY:    if (rdy_ok || tmo) state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request latch, round-robin pointer, watchdog counter and response capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr   <= 1'b0;
      op_q  <= 1'b0;
      id_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
      cnt   <= '0;
      res_q <= '0;
      exc_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= req_op[grant_id];
        id_q  <= grant_id;
        a_q   <= grant_id ? req_a1 : req_a0;
        b_q   <= grant_id ? req_b1 : req_b0;
        tag_q <= grant_id ? req_tag1 : req_tag0;
        ptr   <= ~grant_id;
      end
      if (state == START)
        cnt <= '0;
      else if ((state == BUSY) && !tmo)
        cnt <= cnt + CW'(1);
      if (state == BUSY) begin
        if (rdy_ok) begin
          res_q <= md_result;
          exc_q <= md_exception;
          to_q  <= 1'b0;
        end else if (tmo) begin
          res_q <= '0;
          exc_q <= 1'b1;
          to_q  <= 1'b1;
        end
      end
    end
  end

  assign md_operandA    = a_q;
  assign md_operandB    = b_q;
  assign md_ctrl_MULT   = (state == START) && !op_q;
  assign md_ctrl_DIV    = (state == START) &&  op_q;
  assign resp_valid     = (state == DONE);
  assign resp_id        = id_q;
  assign resp_tag       = tag_q;
  assign resp_result    = res_q;
  assign resp_exception = exc_q;
  assign resp_timeout   = to_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_multdiv_sched.sv
// tb_multdiv_sched: directed tests for multdiv_sched with a behavioural
// multdiv stub that answers a configurable number of cycles after start.
module tb_multdiv_sched;

  localparam int unsigned TIMEOUT = 80;
  localparam int unsigned TAG_W   = 5;

  logic             clock;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_op;
  logic [31:0]      req_a0, req_a1, req_b0, req_b1;
  logic [TAG_W-1:0] req_tag0, req_tag1;
  logic [1:0]       req_ready;
  logic [31:0]      md_operandA, md_operandB;
  logic             md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0]      md_result;
  logic             md_exception;
  logic             md_resultRDY;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      resp_result;
  logic             resp_exception;
  logic             resp_timeout;
  logic             busy;

  int total = 0;
  int bad   = 0;

  // stub_mode: 0 = answer after stub_delay cycles, 1 = never, 2 = ready only
  // during START and the first BUSY cycle
  int stub_mode  = 0;
  int stub_delay = 1;
  int n_mult     = 0;
  int n_div      = 0;

  multdiv_sched #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_op(req_op),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_tag0(req_tag0), .req_tag1(req_tag1), .req_ready(req_ready),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_tag(resp_tag), .resp_result(resp_result),
    .resp_exception(resp_exception), .resp_timeout(resp_timeout), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // multdiv stub
  initial begin
    int cd;
    logic        s_op;
    logic [31:0] sa, sb;
    cd = 0; s_op = 1'b0; sa = '0; sb = '0;
    md_resultRDY = 1'b0; md_result = '0; md_exception = 1'b0;
    forever begin
      @(negedge clock);
      if (md_ctrl_MULT) n_mult++;
      if (md_ctrl_DIV)  n_div++;
      if (md_ctrl_MULT || md_ctrl_DIV) begin
        s_op = md_ctrl_DIV; sa = md_operandA; sb = md_operandB;
        if (stub_mode == 0) begin cd = stub_delay; md_resultRDY = 1'b0; end
        else if (stub_mode == 1) begin cd = 0; md_resultRDY = 1'b0; end
        else begin
          cd = 2; md_resultRDY = 1'b1; md_result = 32'h1234; md_exception = 1'b0;
        end
      end else if (cd > 0) begin
        cd--;
        if (stub_mode == 0) begin
          if (cd == 0) begin
            md_resultRDY = 1'b1;
            if (s_op) begin
              if (sb == 0) begin md_result = 32'hFFFF_FFFF; md_exception = 1'b1; end
              else begin md_result = sa / sb; md_exception = 1'b0; end
            end else begin
              md_result = sa * sb; md_exception = 1'b0;
            end
          end else md_resultRDY = 1'b0;
        end else begin
          md_resultRDY = (cd > 0);
        end
      end else begin
        md_resultRDY = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; resp_ready = 1'b0;
    req_valid = 2'b11; req_op = 2'b00;
    req_a0 = 32'd1; req_a1 = 32'd2; req_b0 = 32'd3; req_b1 = 32'd4;
    req_tag0 = 5'd1; req_tag1 = 5'd2;
    tick();
    total++;
    if ({req_ready, busy, resp_valid, md_ctrl_MULT, md_ctrl_DIV} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {req_ready, busy, resp_valid, md_ctrl_MULT, md_ctrl_DIV});
    end
    total++;
    if ({md_operandA, md_operandB, resp_result, resp_tag, resp_id, resp_exception, resp_timeout} !== '0) begin
      bad++;
      $display("FAIL reset_data got A=%0h B=%0h res=%0h tag=%0d id=%0d exc=%0d to=%0d want all 0",
               md_operandA, md_operandB, resp_result, resp_tag, resp_id, resp_exception, resp_timeout);
    end
    req_valid = 2'b00;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    int k, m0, d0;
    stub_mode = 0; stub_delay = 33;
    m0 = n_mult; d0 = n_div;
    req_valid = 2'b01; req_op = 2'b00; req_a0 = 32'd6; req_b0 = 32'd7; req_tag0 = 5'd3;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL mult_grant got=%b want=01", req_ready); end
    tick();
    req_valid = 2'b00;
    total++;
    if ({md_ctrl_MULT, md_ctrl_DIV} !== 2'b10) begin
      bad++; $display("FAIL mult_pulse got=%b want=10", {md_ctrl_MULT, md_ctrl_DIV});
    end
    total++;
    if ({md_operandA, md_operandB} !== {32'd6, 32'd7}) begin
      bad++; $display("FAIL mult_operands got=%0d,%0d want=6,7", md_operandA, md_operandB);
    end
    tick();
    k = 1;
    total++;
    if ({md_ctrl_MULT, md_ctrl_DIV, busy} !== 3'b001) begin
      bad++; $display("FAIL mult_pulse_end got=%b want=001", {md_ctrl_MULT, md_ctrl_DIV, busy});
    end
    while (!resp_valid && k < 300) begin tick(); k++; end
    total++;
    if (k !== 34) begin bad++; $display("FAIL mult_latency got=%0d want=34", k); end
    total++;
    if (resp_result !== 32'd42) begin bad++; $display("FAIL mult_result got=%0d want=42", resp_result); end
    total++;
    if ({resp_id, resp_tag, resp_exception, resp_timeout} !== {1'b0, 5'd3, 1'b0, 1'b0}) begin
      bad++; $display("FAIL mult_meta got id=%0d tag=%0d exc=%0d to=%0d want 0,3,0,0",
                      resp_id, resp_tag, resp_exception, resp_timeout);
    end
    total++;
    if ((n_mult - m0) != 1 || (n_div - d0) != 0) begin
      bad++; $display("FAIL mult_pulse_count got mult=%0d div=%0d want 1,0", n_mult - m0, n_div - d0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    total++;
    if ({resp_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL mult_release got=%b want=00", {resp_valid, busy});
    end
  endtask

  task automatic test_div_exc();
    int k, m0, d0;
    stub_mode = 0; stub_delay = 5;
    m0 = n_mult; d0 = n_div;
    req_valid = 2'b10; req_op = 2'b10; req_a1 = 32'd100; req_b1 = 32'd0; req_tag1 = 5'd9;
    #1;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL div_grant got=%b want=10", req_ready); end
    tick();
    req_valid = 2'b00;
    total++;
    if ({md_ctrl_MULT, md_ctrl_DIV} !== 2'b01) begin
      bad++; $display("FAIL div_pulse got=%b want=01", {md_ctrl_MULT, md_ctrl_DIV});
    end
    k = 0;
    while (!resp_valid && k < 300) begin tick(); k++; end
    total++;
    if (resp_valid !== 1'b1) begin bad++; $display("FAIL div_resp_valid got=%b want=1", resp_valid); end
    total++;
    if (resp_result !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL div_result got=%0h want=ffffffff", resp_result);
    end
    total++;
    if ({resp_id, resp_tag, resp_exception, resp_timeout} !== {1'b1, 5'd9, 1'b1, 1'b0}) begin
      bad++; $display("FAIL div_meta got id=%0d tag=%0d exc=%0d to=%0d want 1,9,1,0",
                      resp_id, resp_tag, resp_exception, resp_timeout);
    end
    total++;
    if ((n_mult - m0) != 0 || (n_div - d0) != 1) begin
      bad++; $display("FAIL div_pulse_count got mult=%0d div=%0d want 0,1", n_mult - m0, n_div - d0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_arbitration();
    int exp_id[4];
    int exp_res[4];
    int gi, ri, cycles;
    exp_id  = '{0, 1, 0, 1};
    exp_res = '{6, 20, 6, 20};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    stub_mode = 0; stub_delay = 3; resp_ready = 1'b1;
    req_op = 2'b00;
    req_a0 = 32'd2; req_b0 = 32'd3; req_tag0 = 5'd1;
    req_a1 = 32'd4; req_b1 = 32'd5; req_tag1 = 5'd2;
    req_valid = 2'b11;
    #1;
    gi = 0; ri = 0; cycles = 0;
    while (ri < 4 && cycles < 400) begin
      total++;
      if (req_ready == 2'b11 || (busy && req_ready != 2'b00)) begin
        bad++; $display("FAIL arb_ready_legal got ready=%b busy=%b want onehot and idle-only", req_ready, busy);
      end
      if (req_ready != 2'b00 && gi < 4) begin
        total++;
        if (req_ready !== ((exp_id[gi] == 1) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL arb_order grant%0d got=%b want_id=%0d", gi, req_ready, exp_id[gi]);
        end
        gi++;
      end
      if (resp_valid) begin
        total++;
        if ({resp_id, resp_result} !== {exp_id[ri][0], exp_res[ri][31:0]}) begin
          bad++; $display("FAIL arb_resp%0d got id=%0d res=%0d want id=%0d res=%0d",
                          ri, resp_id, resp_result, exp_id[ri], exp_res[ri]);
        end
        ri++;
        if (ri == 4) req_valid = 2'b00;
      end
      if (ri < 4) begin tick(); cycles++; end
    end
    total++;
    if (gi != 4 || ri != 4) begin
      bad++; $display("FAIL arb_progress got grants=%0d resps=%0d want 4,4", gi, ri);
    end
    req_valid = 2'b00;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int k, m0, d0;
    stub_mode = 0; stub_delay = 4; resp_ready = 1'b0;
    req_valid = 2'b01; req_op = 2'b00; req_a0 = 32'd9; req_b0 = 32'd9; req_tag0 = 5'd7;
    tick();
    req_valid = 2'b11;
    k = 0;
    while (!resp_valid && k < 200) begin tick(); k++; end
    m0 = n_mult; d0 = n_div;
    for (int c = 0; c < 5; c++) begin
      total++;
      if ({resp_valid, resp_result, resp_tag, resp_id} !== {1'b1, 32'd81, 5'd7, 1'b0}) begin
        bad++; $display("FAIL bp_hold c=%0d got v=%0d res=%0d tag=%0d id=%0d want 1,81,7,0",
                        c, resp_valid, resp_result, resp_tag, resp_id);
      end
      total++;
      if ({req_ready, md_ctrl_MULT, md_ctrl_DIV} !== 4'b0) begin
        bad++; $display("FAIL bp_no_grant c=%0d got=%b want=0000", c, {req_ready, md_ctrl_MULT, md_ctrl_DIV});
      end
      tick();
    end
    total++;
    if ((n_mult - m0) != 0 || (n_div - d0) != 0) begin
      bad++; $display("FAIL bp_pulses got mult=%0d div=%0d want 0,0", n_mult - m0, n_div - d0);
    end
    resp_ready = 1'b1;
    tick();
    total++;
    if ({resp_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL bp_release got=%b want=00", {resp_valid, busy});
    end
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_next_grant got=%b want=10", req_ready); end
    req_valid = 2'b00; resp_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int k;
    for (int run = 0; run < 2; run++) begin
      stub_mode = (run == 0) ? 1 : 2;
      req_valid = 2'b01; req_op = 2'b00; req_a0 = 32'd1; req_b0 = 32'd1;
      req_tag0 = (run == 0) ? 5'd4 : 5'd5;
      tick();
      req_valid = 2'b00;
      k = 0;
      while (!resp_valid && k < 300) begin tick(); k++; end
      total++;
      if (k !== TIMEOUT + 1) begin
        bad++; $display("FAIL tmo_latency run=%0d got=%0d want=%0d", run, k, TIMEOUT + 1);
      end
      total++;
      if ({resp_result, resp_exception, resp_timeout} !== {32'd0, 1'b1, 1'b1}) begin
        bad++; $display("FAIL tmo_resp run=%0d got res=%0h exc=%0d to=%0d want 0,1,1",
                        run, resp_result, resp_exception, resp_timeout);
      end
      total++;
      if (resp_tag !== ((run == 0) ? 5'd4 : 5'd5)) begin
        bad++; $display("FAIL tmo_tag run=%0d got=%0d want=%0d", run, resp_tag, (run == 0) ? 4 : 5);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end
    stub_mode = 0;
  endtask

  task automatic test_reset_midop();
    int k;
    stub_mode = 0; stub_delay = 10;
    req_valid = 2'b01; req_op = 2'b00; req_a0 = 32'd3; req_b0 = 32'd5; req_tag0 = 5'd6;
    tick();
    req_valid = 2'b00;
    tick(); tick(); tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%b want=1", busy); end
    req_valid = 2'b01;
    reset = 1'b1;
    #1;
    total++;
    if ({req_ready, busy, resp_valid, md_ctrl_MULT, md_ctrl_DIV} !== 6'b0) begin
      bad++; $display("FAIL rst_async_ctrl got=%b want=000000",
                      {req_ready, busy, resp_valid, md_ctrl_MULT, md_ctrl_DIV});
    end
    total++;
    if ({md_operandA, md_operandB, resp_result, resp_tag, resp_id, resp_exception, resp_timeout} !== '0) begin
      bad++; $display("FAIL rst_async_data got A=%0h B=%0h res=%0h tag=%0d id=%0d exc=%0d to=%0d want all 0",
                      md_operandA, md_operandB, resp_result, resp_tag, resp_id, resp_exception, resp_timeout);
    end
    req_valid = 2'b00;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++;
      if ({resp_valid, busy} !== 2'b00) begin
        bad++; $display("FAIL rst_stale_rdy c=%0d got=%b want=00", c, {resp_valid, busy});
      end
    end
    stub_delay = 4;
    req_valid = 2'b11; req_a0 = 32'd3; req_b0 = 32'd5; req_tag0 = 5'd6;
    req_a1 = 32'd8; req_b1 = 32'd8; req_tag1 = 5'd11;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_ptr_grant got=%b want=01", req_ready); end
    tick();
    req_valid = 2'b00;
    k = 0;
    while (!resp_valid && k < 200) begin tick(); k++; end
    total++;
    if ({resp_valid, resp_result, resp_id, resp_tag, resp_timeout} !== {1'b1, 32'd15, 1'b0, 5'd6, 1'b0}) begin
      bad++; $display("FAIL rst_next_op got v=%0d res=%0d id=%0d tag=%0d to=%0d want 1,15,0,6,0",
                      resp_valid, resp_result, resp_id, resp_tag, resp_timeout);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_exc();
    test_arbitration();
    test_backpressure();
    test_timeout();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_sched.md
Name: multdiv_sched

Overview:
Round-robin scheduler that shares the single multdiv unit between two requesters, e.g. the CPU execute stage and the game-logic coprocessor. It arbitrates and latches one request at a time, then issues a one-cycle ctrl_MULT or ctrl_DIV start pulse. It waits for data_resultRDY under a timeout watchdog and returns a tagged response with backpressure. Operands are held stable on the unit for the whole operation.

Parameters:
TIMEOUT, 80, max cycles in BUSY waiting for md_resultRDY before forced completion (must be ≥ 2).
TAG_W, 5, width of the requester tag (destination register number).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  2  per-requester request valid; bit k belongs to requester k.
req_op  in  2  per-requester op: 0 = mult, 1 = div.
req_a0, req_a1  in  32  operand A for requesters 0 and 1.
req_b0, req_b1  in  32  operand B for requesters 0 and 1.
req_tag0, req_tag1  in  TAG_W  tag for requesters 0 and 1.
req_ready  out  2  one-hot grant; handshake on requester k when req_valid[k] & req_ready[k].
md_operandA, md_operandB  out  32  operands driven to the multdiv unit.
md_ctrl_MULT, md_ctrl_DIV  out  1  one-cycle start pulses to the multdiv unit.
md_result  in  32  multdiv data_result.
md_exception  in  1  multdiv data_exception.
md_resultRDY  in  1  multdiv data_resultRDY.
resp_valid  out  1  response available.
resp_ready  in  1  consumer accepts the response.
resp_id  out  1  index of the requester that owns the response.
resp_tag  out  TAG_W  echoed tag.
resp_result  out  32  result.
resp_exception  out  1  md_exception, or 1 on timeout.
resp_timeout  out  1  completion was forced by the watchdog.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- FSM states: IDLE, START, BUSY, DONE.
- Reset (asynchronous, any state): FSM → IDLE.
  - Round-robin pointer → 0.
  - All outputs → 0: req_ready, md_ctrl_*, md_operandA/B, resp_*, busy.
  - An in-flight multdiv operation is abandoned and its later resultRDY is ignored, since the FSM is in IDLE.
- IDLE arbitration (combinational):
  - If exactly one req_valid bit is set, that requester is granted.
  - If both are set, the requester named by the pointer is granted.
  - req_ready is high only in IDLE and only for the granted requester; at most one bit is ever set.
- IDLE handshake:
  - Latch op, A, B, tag and id into internal registers.
  - Set the pointer to the other requester's index.
  - Next state is START.
- START (exactly 1 cycle):
  - md_operandA/B carry the latched operands; they stay stable through START and BUSY.
  - md_ctrl_MULT = ~op and md_ctrl_DIV = op for this cycle only; never both high.
  - Clear the wait counter; next state is BUSY.
- BUSY:
  - The wait counter increments every cycle.
  - md_resultRDY is ignored in the first BUSY cycle (counter == 0), to avoid stale ready from the previous operation.
  - When the counter is ≥ 1 and md_resultRDY = 1: capture md_result and md_exception, set resp_timeout = 0, go to DONE.
  - When the counter reaches TIMEOUT-1 with no qualifying RDY: resp_result = 0, resp_exception = 1, resp_timeout = 1, go to DONE.
  - If a valid RDY and the timeout occur in the same cycle, RDY wins.
- DONE:
  - resp_valid = 1; all resp_* outputs are held stable.
  - When resp_ready = 1: next state is IDLE and resp_valid drops the next cycle.
  - No request is accepted in the same cycle as the response handshake. Minimum spacing is 1 IDLE cycle between operations.
- Latency: accept at cycle N, ctrl pulse at N+1, BUSY from N+2. resp_valid rises 1 cycle after the qualifying RDY.
- The multdiv unit sees exactly one start pulse per accepted request.
- Requests that are not granted must hold their values; the scheduler does not sample them.
- Counter width: clog2(TIMEOUT) bits, saturating (never wraps).

Test Plan:
1. Mult result: req0 mult A=6, B=7, tag=3 with a stub unit raising RDY 33 cycles after start.
   - md_ctrl_MULT high for exactly 1 cycle at N+1; md_ctrl_DIV stays 0.
   - Response: result=42, id=0, tag=3, exception=0, timeout=0.
2. Div exception: req1 div A=100, B=0; stub returns exception=1.
   - Single md_ctrl_DIV pulse.
   - Response: exception=1, timeout=0, id=1; the response reports exactly what the stub returned.
3. Arbitration: both requesters valid continuously after reset.
   - Grant order 0, 1, 0, 1.
   - req_ready never has 2 bits set; no grant while busy=1.
4. Backpressure: hold resp_ready=0 for 5 cycles in DONE.
   - resp_* stays stable and resp_valid stays 1.
   - req_ready stays 0 and no md_ctrl pulse is issued.
   - After resp_ready=1: IDLE the next cycle, then a new grant.
5. Timeout and stale ready: stub never raises RDY, then a second run raises RDY during START and the first BUSY cycle only.
   - Never-RDY run: after TIMEOUT BUSY cycles, resp_result=0, exception=1, timeout=1.
   - Early-RDY run: the early pulses are ignored.
6. Reset mid-op: assert reset during BUSY, then let the stub raise RDY.
   - All outputs are 0 immediately, asynchronously.
   - The later RDY produces no response; the next request is handled normally with the pointer at 0.
